// File: rtl/prog_sequencer.sv
// prog_sequencer
//
// Run controller for the instruction-fetch unit. It runs NUM_PROGS programs
// one after another. For each program it holds fetch in reset at the
// program's start address for RESET_CYCLES cycles. It then releases fetch
// and counts run cycles until fetch raises halt or MAX_CYCLES run cycles
// pass without a halt. The count is reported for one cycle, then the next
// program starts.
//
// Ports:
//   clk             clock; all logic is on the rising edge
//   reset           synchronous, active-high; aborts any sequence in progress
//   start           begins a run sequence; sampled only in IDLE and FINISH
//   start_addrs     packed start addresses; program i is at [i*A +: A]
//   halt            halt flag from fetch
//   if_reset        reset to fetch; low only while a program runs
//   inst_addr_reset reset address to fetch, start_addrs[prog_idx]
//   prog_idx        index of the current program
//   running         high while fetch is released (RUN)
//   cycles          cycle count of the last finished program
//   cycles_valid    one-cycle pulse when cycles/timed_out are updated
//   timed_out       last program hit MAX_CYCLES without halting
//   all_done        high once every program has been run (FINISH)

module prog_sequencer #(
  parameter int A            = 4,
  parameter int NUM_PROGS    = 3,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 1000,
  parameter int CYCLE_W      = 16,
  localparam int IDX_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PROGS*A-1:0] start_addrs,
  input  logic                   halt,
  output logic                   if_reset,
  output logic [A-1:0]           inst_addr_reset,
  output logic [IDX_W-1:0]       prog_idx,
  output logic                   running,
  output logic [CYCLE_W-1:0]     cycles,
  output logic                   cycles_valid,
  output logic                   timed_out,
  output logic                   all_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_REPORT = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [CYCLE_W-1:0] LOAD_LAST = CYCLE_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] RUN_LAST  = CYCLE_W'(MAX_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] MAX_VAL   = CYCLE_W'(MAX_CYCLES);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PROGS - 1);
  localparam int                 TBL_SIZE  = 2 ** IDX_W;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   prog_idx_reg, prog_idx_next;
  // Shared counter: counts held-reset cycles in LOAD and run cycles in RUN.
  logic [CYCLE_W-1:0] cnt_reg, cnt_next;
  logic [CYCLE_W-1:0] cycles_reg, cycles_next;
  logic               timed_out_reg, timed_out_next;

  // Address table padded to a power of two. Every value of prog_idx then
  // selects a defined entry. Indices at or above NUM_PROGS are never
  // reached and read as zero.
  logic [A-1:0] addr_tbl [TBL_SIZE];

  generate
    for (genvar gi = 0; gi < TBL_SIZE; gi++) begin : g_addr_tbl
      if (gi < NUM_PROGS) begin : g_used
        assign addr_tbl[gi] = start_addrs[gi*A +: A];
      end else begin : g_unused
        assign addr_tbl[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      prog_idx_reg  <= '0;
      cnt_reg       <= '0;
      cycles_reg    <= '0;
      timed_out_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prog_idx_reg  <= prog_idx_next;
      cnt_reg       <= cnt_next;
      cycles_reg    <= cycles_next;
      timed_out_reg <= timed_out_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prog_idx_next  = prog_idx_reg;
    cnt_next       = cnt_reg;
    cycles_next    = cycles_reg;
    timed_out_next = timed_out_reg;

    unique case (state_reg)
      S_IDLE, S_FINISH: begin
        if (start) begin
          prog_idx_next = '0;
          cnt_next      = '0;
          state_next    = S_LOAD;
        end
      end

      S_LOAD: begin
        if (cnt_reg == LOAD_LAST) begin
          cnt_next   = '0;
          state_next = S_RUN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_RUN: begin
        // A halt in the final run cycle still counts as a halt, so it is
        // tested before the timeout.
        if (halt) begin
          cycles_next    = cnt_reg;
          timed_out_next = 1'b0;
          state_next     = S_REPORT;
        end else if (cnt_reg == RUN_LAST) begin
          cycles_next    = MAX_VAL;
          timed_out_next = 1'b1;
          state_next     = S_REPORT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      S_REPORT: begin
        if (prog_idx_reg == LAST_IDX) begin
          state_next = S_FINISH;
        end else begin
          prog_idx_next = prog_idx_reg + 1'b1;
          cnt_next      = '0;
          state_next    = S_LOAD;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so there is no
  // combinational path from halt or start to any output.
  assign if_reset        = (state_reg != S_RUN);
  assign running         = (state_reg == S_RUN);
  assign cycles_valid    = (state_reg == S_REPORT);
  assign all_done        = (state_reg == S_FINISH);
  assign prog_idx        = prog_idx_reg;
  assign cycles          = cycles_reg;
  assign timed_out       = timed_out_reg;
  assign inst_addr_reset = addr_tbl[prog_idx_reg];

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer. A small fetch model drives halt.
// It picks its halt delay from the reset address it was released at, so a
// wrong address shows up as a wrong cycle count.
module tb_prog_sequencer;
  localparam int A  = 4;
  localparam int NP = 3;
  localparam int RC = 2;
  localparam int MC = 20;
  localparam int CW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [NP*A-1:0] start_addrs = {4'd10, 4'd5, 4'd0};
  logic            halt;
  logic            if_reset;
  logic [A-1:0]    inst_addr_reset;
  logic [IW-1:0]   prog_idx;
  logic            running;
  logic [CW-1:0]   cycles;
  logic            cycles_valid;
  logic            timed_out;
  logic            all_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prog_sequencer #(
    .A(A), .NUM_PROGS(NP), .RESET_CYCLES(RC), .MAX_CYCLES(MC), .CYCLE_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addrs(start_addrs),
    .halt(halt), .if_reset(if_reset), .inst_addr_reset(inst_addr_reset),
    .prog_idx(prog_idx), .running(running), .cycles(cycles),
    .cycles_valid(cycles_valid), .timed_out(timed_out), .all_done(all_done)
  );

  // Fetch model: counts run cycles since release and halts after the delay
  // assigned to the address it was released at (255 = never halts).
  logic [7:0] run_cnt;
  logic [7:0] d0 = 8'd7, d1 = 8'd3, d2 = 8'd12;
  logic [7:0] cur_delay;

  always @(posedge clk) begin
    if (if_reset !== 1'b0) run_cnt <= 8'd0;
    else                   run_cnt <= run_cnt + 8'd1;
  end

  always_comb begin
    cur_delay = 8'hff;
    case (inst_addr_reset)
      4'd0:    cur_delay = d0;
      4'd5:    cur_delay = d1;
      4'd10:   cur_delay = d2;
      default: cur_delay = 8'hff;
    endcase
  end

  assign halt = (if_reset == 1'b0) && (run_cnt == cur_delay);

  // Pulse recorder: logs every cycles_valid pulse.
  int          n_pulse = 0;
  logic [15:0] p_cyc [64];
  logic        p_to  [64];
  logic [1:0]  p_idx [64];

  always @(negedge clk) begin
    if (cycles_valid === 1'b1 && n_pulse < 64) begin
      p_cyc[n_pulse] <= cycles;
      p_to[n_pulse]  <= timed_out;
      p_idx[n_pulse] <= prog_idx;
      n_pulse        <= n_pulse + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a sequence, checks the LOAD-to-RUN latency, then waits for FINISH.
  task automatic run_seq(input logic hold);
    int n;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    chk("load1_running", running, 0);
    chk("load1_if_reset", if_reset, 1);
    tick();
    chk("load2_running", running, 0);
    tick();
    chk("run_entry_running", running, 1);
    chk("run_entry_if_reset", if_reset, 0);
    n = 0;
    while (all_done !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    start = 1'b0;
    chk("all_done", all_done, 1);
    chk("final_prog_idx", prog_idx, 2);
  endtask

  task automatic check_seq(input int base, input int c0, input int c1, input int c2,
                           input logic t1);
    int ec[3];
    ec = '{c0, c1, c2};
    chk("pulse_count", n_pulse - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("cycles[%0d]", i), p_cyc[base+i], ec[i]);
      chk($sformatf("prog_idx[%0d]", i), p_idx[base+i], i);
      chk($sformatf("timed_out[%0d]", i), p_to[base+i], (i == 1) ? t1 : 1'b0);
    end
  endtask

  initial begin
    int base;
    int n;

    // Reset, then idle.
    repeat (3) tick();
    chk("rst_if_reset", if_reset, 1);
    chk("rst_prog_idx", prog_idx, 0);
    chk("rst_running", running, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_cycles_valid", cycles_valid, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_all_done", all_done, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_if_reset", if_reset, 1);
      chk("idle_running", running, 0);
      chk("idle_all_done", all_done, 0);
      chk("idle_addr", inst_addr_reset, 0);
    end
    $display("step idle: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Three programs halting after 7, 3, 12.
    base = n_pulse;
    run_seq(1'b0);
    check_seq(base, 7, 3, 12, 1'b0);
    $display("step three-program: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Restart from FINISH; program 1 never halts.
    d0 = 8'd5; d1 = 8'hff; d2 = 8'd4;
    base = n_pulse;
    run_seq(1'b0);
    check_seq(base, 5, 20, 4, 1'b1);
    $display("step timeout: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Boundaries: halt in first RUN cycle, and halt on the last counted cycle.
    d0 = 8'd0; d1 = 8'd19; d2 = 8'd1;
    base = n_pulse;
    run_seq(1'b0);
    check_seq(base, 0, 19, 1, 1'b0);
    $display("step boundary: vectors=%0d miscompares=%0d", vectors, miscompares);

    // Reset during program 1's RUN.
    d0 = 8'd3; d1 = 8'd15; d2 = 8'd2;
    base = n_pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(running === 1'b1 && inst_addr_reset === 4'd5) && n < 200) begin
      tick();
      n++;
    end
    chk("abort_reached_prog1", prog_idx, 1);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_running", running, 0);
    chk("abort_if_reset", if_reset, 1);
    chk("abort_prog_idx", prog_idx, 0);
    chk("abort_cycles", cycles, 0);
    chk("abort_all_done", all_done, 0);
    repeat (5) tick();
    chk("abort_pulse_count", n_pulse - base, 1);
    chk("abort_first_cycles", p_cyc[base], 3);
    chk("abort_idle_running", running, 0);
    base = n_pulse;
    run_seq(1'b0);
    check_seq(base, 3, 15, 2, 1'b0);
    $display("step reset-mid-run: vectors=%0d miscompares=%0d", vectors, miscompares);

    // start held high for the whole sequence.
    d0 = 8'd2; d1 = 8'd6; d2 = 8'd9;
    base = n_pulse;
    run_seq(1'b1);
    check_seq(base, 2, 6, 9, 1'b0);
    repeat (3) tick();
    chk("finish_holds", all_done, 1);
    chk("finish_no_pulse", n_pulse - base, 3);
    $display("step start-held: vectors=%0d miscompares=%0d", vectors, miscompares);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the instruction-fetch unit in the x9 core test harness. Runs NUM_PROGS programs back to back. For each program it holds fetch in reset at that program's start address, releases it, and counts cycles until fetch raises halt or a timeout expires. It then reports the cycle count and moves to the next program. It sits between the testbench/top level and the fetch stage, driving fetch's reset and reset-address inputs.

## Interface
- A, 4: instruction address width; matches fetch.
- NUM_PROGS, 3: number of programs to run (1..16).
- RESET_CYCLES, 2: cycles fetch reset is held per program (>=1).
- MAX_CYCLES, 1000: run-cycle timeout per program (>=1).
- CYCLE_W, 16: cycle-counter width; must hold MAX_CYCLES.

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run sequence; sampled in IDLE and FINISH only.
- start_addrs  in  NUM_PROGS*A  packed start addresses; program i is at bits [i*A +: A].
- halt  in  1  halt flag from fetch.
- if_reset  out  1  reset to fetch.
- inst_addr_reset  out  A  reset address to fetch.
- prog_idx  out  $clog2(NUM_PROGS) (min 1)  index of the current program.
- running  out  1  high in RUN.
- cycles  out  CYCLE_W  cycle count of the last finished program.
- cycles_valid  out  1  one-cycle pulse when cycles/timed_out are updated.
- timed_out  out  1  last program hit MAX_CYCLES without halting.
- all_done  out  1  high in FINISH.

## Operation
- State IDLE.
  - if_reset=1.
  - On start: prog_idx<=0, load counter<=0, go to LOAD.
- State LOAD.
  - if_reset=1; inst_addr_reset=start_addrs[prog_idx].
  - Stays exactly RESET_CYCLES cycles, then goes to RUN with run counter<=0.
- State RUN.
  - if_reset=0; running=1.
  - Each cycle with halt=0: counter+1.
  - Cycle with halt=1: cycles<=counter, timed_out<=0, go to REPORT.
  - If halt=0 and counter==MAX_CYCLES-1: cycles<=MAX_CYCLES, timed_out<=1, go to REPORT.
  - Halt takes priority over timeout in the same cycle.
- State REPORT.
  - if_reset=1; cycles_valid=1 for this single cycle.
  - If prog_idx==NUM_PROGS-1: go to FINISH.
  - Else: prog_idx+1, go to LOAD.
- State FINISH.
  - if_reset=1; all_done=1.
  - start restarts the sequence exactly as from IDLE.
- inst_addr_reset always shows start_addrs[prog_idx], in every state.
- start is ignored in LOAD, RUN and REPORT.
- The reset cycles in LOAD clear fetch's halt before RUN, so a stale halt from the previous program is never seen.
- The counter never wraps; MAX_CYCLES bounds it.

## Timing
- Reset values:
  - state=IDLE, if_reset=1, prog_idx=0, running=0.
  - cycles=0, cycles_valid=0, timed_out=0, all_done=0.
- reset has priority over every state. Asserting it mid-RUN aborts the sequence at the next edge. No cycles_valid is produced for the aborted program.
- start high at edge T: LOAD from T+1 through T+RESET_CYCLES; RUN begins at T+RESET_CYCLES+1.
- Fetch runs for each RUN cycle with halt=0. If halt is first seen high N RUN cycles after RUN entry:
  - cycles=N.
  - cycles_valid pulses in the following cycle.
  - Next LOAD starts one cycle later.
- Per-program overhead: RESET_CYCLES+1 cycles (LOAD plus REPORT).
- cycles, timed_out and prog_idx are stable while cycles_valid is high.
- cycles and timed_out hold their values until the next REPORT.

## Test plan
- Reset then idle:
  - Stimulus: reset for 3 cycles, start=0 for 20 cycles.
  - Required: if_reset=1, running=0 and all_done=0 throughout; inst_addr_reset=start_addrs[0].
- Three-program run:
  - Stimulus: A=4, start_addrs={4'd10,4'd5,4'd0}; fetch model halts 7, 3 and 12 run-cycles after release.
  - Required: three cycles_valid pulses with cycles=7, 3, 12 and prog_idx=0, 1, 2; all_done high after the third pulse.
- Timeout:
  - Stimulus: MAX_CYCLES=20; program 1 never halts.
  - Required: cycles=20 and timed_out=1 on its pulse; program 2 still runs normally with timed_out=0.
- Boundary:
  - Stimulus: halt rises in the first RUN cycle.
  - Required: cycles=0.
  - Stimulus: halt rises on the cycle with counter==MAX_CYCLES-1.
  - Required: timed_out=0.
- Reset mid-run:
  - Stimulus: assert reset during program 1's RUN, then start again.
  - Required: no pulse for the aborted program; the sequence restarts at prog_idx=0 with correct counts.
- Restart and start-ignore:
  - Stimulus: pulse start in FINISH.
  - Required: full sequence repeats.
  - Stimulus: hold start high through the whole run.
  - Required: no extra restarts until FINISH is reached.
